collatz_sequencer: RTL and testbench

//  Control FSM for the uDATAPATH Collatz datapath. On start it loads n from the fixed-register input into R3 and iterates
//  n -> n/2 (even) or n -> 3n+1 (odd) until n==1, counting steps. Sits beside uDATAPATH and drives all of its selection and

---
 rtl/collatz_pkg.sv | 76 +++++++
 rtl/collatz_ctrl_rom.sv | 50 +++++
 rtl/collatz_sequencer.sv | 111 +++++++++++
 tb/tb_collatz_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared encodings for the Collatz sequencer: FSM states, datapath select codes,
// ALU opcodes, shifter modes and the packed control word driven onto uDATAPATH.
package collatz_pkg;

  localparam int unsigned DEC_W = 3;
  localparam int unsigned MUX_W = 3;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned SH_W  = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_W,
    S_TEST,
    S_EV_A,
    S_EV_SH,
    S_EV_W,
    S_OD_A1,
    S_OD_W1,
    S_OD_A2,
    S_OD_W2,
    S_OD_A3,
    S_OD_W3,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [DEC_W-1:0] SEL_R0   = 3'd0;
  localparam logic [DEC_W-1:0] SEL_R1   = 3'd1;
  localparam logic [DEC_W-1:0] SEL_R2   = 3'd2;
  localparam logic [DEC_W-1:0] SEL_R3   = 3'd3;
  localparam logic [DEC_W-1:0] SEL_NONE = 3'd7;

  localparam logic [MUX_W-1:0] MUX_R0     = 3'd0;
  localparam logic [MUX_W-1:0] MUX_R1     = 3'd1;
  localparam logic [MUX_W-1:0] MUX_R2     = 3'd2;
  localparam logic [MUX_W-1:0] MUX_R3     = 3'd3;
  localparam logic [MUX_W-1:0] MUX_FIXED0 = 3'd4;
  localparam logic [MUX_W-1:0] MUX_FIXED1 = 3'd5;

  localparam logic [ALU_W-1:0] ALU_PASSA = 4'd0;
  localparam logic [ALU_W-1:0] ALU_ADD   = 4'd1;
  localparam logic [ALU_W-1:0] ALU_INCA  = 4'd2;

  localparam logic [SH_W-1:0] SH_HOLD  = 2'b11;
  localparam logic [SH_W-1:0] SH_RIGHT = 2'b01;
  localparam logic [SH_W-1:0] SH_LEFT  = 2'b10;

  typedef struct packed {
    logic [DEC_W-1:0] clr_sel;
    logic [DEC_W-1:0] ld_sel;
    logic [MUX_W-1:0] mux_a;
    logic [MUX_W-1:0] mux_b;
    logic [ALU_W-1:0] alu;
    logic             sh_clr_n;
    logic             sh_ld_n;
    logic [SH_W-1:0]  sh_mode;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    clr_sel:  SEL_NONE,
    ld_sel:   SEL_NONE,
    mux_a:    MUX_R0,
    mux_b:    MUX_R0,
    alu:      ALU_PASSA,
    sh_clr_n: 1'b1,
    sh_ld_n:  1'b1,
    sh_mode:  SH_HOLD
  };

  // Resting states: start is only accepted here and busy is low.
  function automatic logic is_rest(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

endpackage

// File: rtl/collatz_ctrl_rom.sv
// Combinational state -> datapath control word table.
// Each datapath op takes two cycles: ALU result into the shifter, then shifter into Rx.
module collatz_ctrl_rom
  import collatz_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_NOP;
    case (state_i)
      S_LOAD_A: begin
        ctrl_o.mux_a   = MUX_FIXED0;
        ctrl_o.alu     = ALU_PASSA;
        ctrl_o.sh_ld_n = 1'b0;
      end
      S_LOAD_W: ctrl_o.ld_sel = SEL_R3;
      S_EV_A: begin
        ctrl_o.mux_a   = MUX_R3;
        ctrl_o.alu     = ALU_PASSA;
        ctrl_o.sh_ld_n = 1'b0;
      end
      S_EV_SH: ctrl_o.sh_mode = SH_RIGHT;
      S_EV_W:  ctrl_o.ld_sel  = SEL_R3;
      S_OD_A1: begin
        ctrl_o.mux_a   = MUX_R3;
        ctrl_o.mux_b   = MUX_R3;
        ctrl_o.alu     = ALU_ADD;
        ctrl_o.sh_ld_n = 1'b0;
      end
      S_OD_W1: ctrl_o.ld_sel = SEL_R1;
      S_OD_A2: begin
        ctrl_o.mux_a   = MUX_R1;
        ctrl_o.mux_b   = MUX_R3;
        ctrl_o.alu     = ALU_ADD;
        ctrl_o.sh_ld_n = 1'b0;
      end
      S_OD_W2: ctrl_o.ld_sel = SEL_R1;
      S_OD_A3: begin
        ctrl_o.mux_a   = MUX_R1;
        ctrl_o.alu     = ALU_INCA;
        ctrl_o.sh_ld_n = 1'b0;
      end
      S_OD_W3: ctrl_o.ld_sel = SEL_R3;
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/collatz_sequencer.sv
// Collatz control FSM driving uDATAPATH: loads n into R3, iterates n/2 or 3n+1 until 1,
// counting steps and flagging n==0 or 8-bit overflow.
module collatz_sequencer
  import collatz_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS               = 8,
  parameter int unsigned DATAWIDTH_DECODER_SELECTION = 3,
  parameter int unsigned DATAWIDTH_MUX_SELECTION     = 3,
  parameter int unsigned DATAWIDTH_ALU_SELECTION     = 4,
  parameter int unsigned STEPS_WIDTH                 = 8
) (
  input  logic                                   uCOLLATZ_CLOCK_50,
  input  logic                                   uCOLLATZ_RESET_InHigh,
  input  logic                                   uCOLLATZ_start_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]               uCOLLATZ_data_InBUS,
  input  logic                                   uCOLLATZ_carry_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCOLLATZ_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCOLLATZ_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     uCOLLATZ_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]     uCOLLATZ_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     uCOLLATZ_aluselection_OutBUS,
  output logic                                   uCOLLATZ_regSHIFTERclear_OutLow,
  output logic                                   uCOLLATZ_regSHIFTERload_OutLow,
  output logic [1:0]                             uCOLLATZ_regSHIFTERshiftselection_OutLow,
  output logic                                   uCOLLATZ_busy_OutHigh,
  output logic                                   uCOLLATZ_done_OutHigh,
  output logic                                   uCOLLATZ_error_OutHigh,
  output logic [STEPS_WIDTH-1:0]                 uCOLLATZ_steps_OutBUS
);

  state_t                 state_q, state_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic                   busy_q, done_q, error_q;
  logic [STEPS_WIDTH-1:0] steps_q, steps_d;
  logic                   start_ok;

  assign start_ok = is_rest(state_q) && uCOLLATZ_start_InHigh;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (uCOLLATZ_start_InHigh) state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_W;
      S_LOAD_W: state_d = S_TEST;
      S_TEST: begin
        if (uCOLLATZ_data_InBUS == '0)                          state_d = S_ERROR;
        else if (uCOLLATZ_data_InBUS == DATAWIDTH_BUS'(1))      state_d = S_DONE;
        else if (!uCOLLATZ_data_InBUS[0])                       state_d = S_EV_A;
        else                                                    state_d = S_OD_A1;
      end
      S_EV_A:  state_d = S_EV_SH;
      S_EV_SH: state_d = S_EV_W;
      S_EV_W:  state_d = S_TEST;
      // Carry out of any 3n+1 partial sum aborts before the result reaches a register.
      S_OD_A1: state_d = uCOLLATZ_carry_InLow ? S_OD_W1 : S_ERROR;
      S_OD_W1: state_d = S_OD_A2;
      S_OD_A2: state_d = uCOLLATZ_carry_InLow ? S_OD_W2 : S_ERROR;
      S_OD_W2: state_d = S_OD_A3;
      S_OD_A3: state_d = uCOLLATZ_carry_InLow ? S_OD_W3 : S_ERROR;
      S_OD_W3: state_d = S_TEST;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    steps_d = steps_q;
    if (start_ok) begin
      steps_d = '0;
    end else if ((state_q == S_EV_W || state_q == S_OD_W3) && steps_q != '1) begin
      steps_d = steps_q + STEPS_WIDTH'(1);
    end
  end

  // Decoding the next state keeps the registered control word aligned with state_q.
  collatz_ctrl_rom u_rom (
    .state_i (state_d),
    .ctrl_o  (ctrl_d)
  );

  always_ff @(posedge uCOLLATZ_CLOCK_50) begin
    if (uCOLLATZ_RESET_InHigh) begin
      state_q <= S_IDLE;
      ctrl_q  <= CTRL_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= !is_rest(state_d);
      done_q  <= (state_d == S_DONE);
      error_q <= (state_d == S_ERROR);
      steps_q <= steps_d;
    end
  end

  assign uCOLLATZ_decoderclearselection_OutBUS    = DATAWIDTH_DECODER_SELECTION'(ctrl_q.clr_sel);
  assign uCOLLATZ_decoderloadselection_OutBUS     = DATAWIDTH_DECODER_SELECTION'(ctrl_q.ld_sel);
  assign uCOLLATZ_muxselectionBUSA_OutBUS         = DATAWIDTH_MUX_SELECTION'(ctrl_q.mux_a);
  assign uCOLLATZ_muxselectionBUSB_OutBUS         = DATAWIDTH_MUX_SELECTION'(ctrl_q.mux_b);
  assign uCOLLATZ_aluselection_OutBUS             = DATAWIDTH_ALU_SELECTION'(ctrl_q.alu);
  assign uCOLLATZ_regSHIFTERclear_OutLow          = ctrl_q.sh_clr_n;
  assign uCOLLATZ_regSHIFTERload_OutLow           = ctrl_q.sh_ld_n;
  assign uCOLLATZ_regSHIFTERshiftselection_OutLow = ctrl_q.sh_mode;
  assign uCOLLATZ_busy_OutHigh                    = busy_q;
  assign uCOLLATZ_done_OutHigh                    = done_q;
  assign uCOLLATZ_error_OutHigh                   = error_q;
  assign uCOLLATZ_steps_OutBUS                    = steps_q;

endmodule

// File: tb/tb_collatz_sequencer.sv
// Bench for collatz_sequencer with a behavioural uDATAPATH model (R0..R3, shifter, ALU)
// and directed runs with hand-computed step counts, latencies and R3 traces.
module tb_collatz_sequencer;
  import collatz_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bus;
  logic       carry_n;
  logic [2:0] clr_sel, ld_sel, mux_a, mux_b;
  logic [3:0] alu;
  logic       sh_clr_n, sh_ld_n;
  logic [1:0] sh_mode;
  logic       busy, done, error;
  logic [7:0] steps;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  collatz_sequencer #(
    .DATAWIDTH_BUS               (8),
    .DATAWIDTH_DECODER_SELECTION (3),
    .DATAWIDTH_MUX_SELECTION     (3),
    .DATAWIDTH_ALU_SELECTION     (4),
    .STEPS_WIDTH                 (8)
  ) dut (
    .uCOLLATZ_CLOCK_50                        (clk),
    .uCOLLATZ_RESET_InHigh                    (rst),
    .uCOLLATZ_start_InHigh                    (start),
    .uCOLLATZ_data_InBUS                      (bus),
    .uCOLLATZ_carry_InLow                     (carry_n),
    .uCOLLATZ_decoderclearselection_OutBUS    (clr_sel),
    .uCOLLATZ_decoderloadselection_OutBUS     (ld_sel),
    .uCOLLATZ_muxselectionBUSA_OutBUS         (mux_a),
    .uCOLLATZ_muxselectionBUSB_OutBUS         (mux_b),
    .uCOLLATZ_aluselection_OutBUS             (alu),
    .uCOLLATZ_regSHIFTERclear_OutLow          (sh_clr_n),
    .uCOLLATZ_regSHIFTERload_OutLow           (sh_ld_n),
    .uCOLLATZ_regSHIFTERshiftselection_OutLow (sh_mode),
    .uCOLLATZ_busy_OutHigh                    (busy),
    .uCOLLATZ_done_OutHigh                    (done),
    .uCOLLATZ_error_OutHigh                   (error),
    .uCOLLATZ_steps_OutBUS                    (steps)
  );

  always #10 clk = ~clk;

  // Datapath model
  logic [7:0] r [4];
  logic [7:0] shreg;
  logic [7:0] n_fixed;
  logic [7:0] opa, opb;
  logic [8:0] alu_res;
  logic [7:0] trace [$];

  function automatic logic [7:0] pick(input logic [2:0] sel, input logic [7:0] r0,
                                      input logic [7:0] r1, input logic [7:0] r2,
                                      input logic [7:0] r3, input logic [7:0] f0);
    case (sel)
      3'd0: return r0;
      3'd1: return r1;
      3'd2: return r2;
      3'd3: return r3;
      3'd4: return f0;
      3'd5: return 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    opa = pick(mux_a, r[0], r[1], r[2], r[3], n_fixed);
    opb = pick(mux_b, r[0], r[1], r[2], r[3], n_fixed);
    case (alu)
      4'd0:    alu_res = {1'b0, opa};
      4'd1:    alu_res = {1'b0, opa} + {1'b0, opb};
      4'd2:    alu_res = {1'b0, opa} + 9'd1;
      default: alu_res = '0;
    endcase
  end

  assign bus     = r[3];
  assign carry_n = ~alu_res[8];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
      shreg <= '0;
    end else begin
      if (clr_sel < 3'd4) r[clr_sel[1:0]] <= '0;
      if (ld_sel < 3'd4) r[ld_sel[1:0]] <= shreg;
      if (ld_sel == 3'd3) trace.push_back(shreg);
      if (!sh_clr_n)              shreg <= '0;
      else if (!sh_ld_n)          shreg <= alu_res[7:0];
      else if (sh_mode == 2'b01)  shreg <= {1'b0, shreg[7:1]};
      else if (sh_mode == 2'b10)  shreg <= {shreg[6:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Pulses start after an edge, then counts edges until done/error (budget+1 if never).
  task automatic run(input logic [7:0] n, input int unsigned budget,
                     input int unsigned pulse_at, output int unsigned cyc);
    n_fixed = n;
    trace.delete();
    @(posedge clk); #1 start = 1'b1;
    cyc = budget + 1;
    for (int unsigned c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = (pulse_at != 0) && (c == pulse_at);
      if (c == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (done || error) begin
        cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  function automatic logic [7:0] peak_of_trace();
    logic [7:0] m = '0;
    foreach (trace[i]) if (trace[i] > m) m = trace[i];
    return m;
  endfunction

  int unsigned cyc;
  int unsigned seen;
  logic [7:0]  exp6 [9] = '{8'd6, 8'd3, 8'd10, 8'd5, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};

  initial begin
    rst = 1'b1; start = 1'b0; n_fixed = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_steps", {24'd0, steps}, 32'd0);
    check("rst_ctrl",  {16'd0, clr_sel, ld_sel, mux_a, mux_b, alu, sh_clr_n, sh_ld_n, sh_mode},
                       {16'd0, 3'd7, 3'd7, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 2'b11});
    rst = 1'b0;

    // n=1: done four edges after start is applied
    run(8'd1, 20, 0, cyc);
    check("n1_cycles", cyc, 32'd4);
    check("n1_done",   {31'd0, done},  32'd1);
    check("n1_error",  {31'd0, error}, 32'd0);
    check("n1_steps",  {24'd0, steps}, 32'd0);
    check("n1_r3",     {24'd0, bus},   32'd1);
    check("n1_busy",   {31'd0, busy},  32'd0);

    // n=6 with an ignored start pulse mid-run
    run(8'd6, 200, 10, cyc);
    check("n6_cycles", cyc, 32'd42);
    check("n6_done",   {31'd0, done},  32'd1);
    check("n6_steps",  {24'd0, steps}, 32'd8);
    check("n6_r3",     {24'd0, bus},   32'd1);
    check("n6_trace_len", trace.size(), 32'd9);
    for (int i = 0; i < 9; i++)
      check("n6_trace", (i < trace.size()) ? {24'd0, trace[i]} : 32'hFFFF_FFFF, {24'd0, exp6[i]});

    // n=7: longest clean run, peak 52
    run(8'd7, 300, 0, cyc);
    check("n7_cycles", cyc, 32'd83);
    check("n7_done",   {31'd0, done},  32'd1);
    check("n7_error",  {31'd0, error}, 32'd0);
    check("n7_steps",  {24'd0, steps}, 32'd16);
    check("n7_peak",   {24'd0, peak_of_trace()}, 32'd52);

    // n=0: error straight out of TEST
    run(8'd0, 20, 0, cyc);
    check("n0_cycles", cyc, 32'd4);
    check("n0_error",  {31'd0, error}, 32'd1);
    check("n0_done",   {31'd0, done},  32'd0);
    check("n0_steps",  {24'd0, steps}, 32'd0);

    // n=85: 255+1 carries in OD_A3
    run(8'd85, 40, 0, cyc);
    check("n85_cycles", cyc, 32'd9);
    check("n85_error",  {31'd0, error}, 32'd1);
    check("n85_steps",  {24'd0, steps}, 32'd0);
    check("n85_r3",     {24'd0, bus},   32'd85);

    // n=27 overflows at 107*3, then n=6 recovers from ERROR
    run(8'd27, 300, 0, cyc);
    check("n27_error", {31'd0, error}, 32'd1);
    check("n27_done",  {31'd0, done},  32'd0);
    check("n27_steps", {24'd0, steps}, 32'd11);
    check("n27_r3",    {24'd0, bus},   32'd107);
    run(8'd6, 200, 0, cyc);
    check("n6b_done",  {31'd0, done},  32'd1);
    check("n6b_error", {31'd0, error}, 32'd0);
    check("n6b_steps", {24'd0, steps}, 32'd8);

    // n=7 reset in the second OD_W2 (steps=2 there)
    n_fixed = 8'd7;
    trace.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int unsigned c = 0; c < 100 && seen < 2; c++) begin
      @(posedge clk); #1;
      if (mux_a == 3'd1 && alu == 4'd1) seen++;
    end
    check("rst_mid_found", seen, 32'd2);
    @(posedge clk); #1;
    check("rst_mid_in_w2", {29'd0, ld_sel}, 32'd1);
    check("rst_mid_steps_before", {24'd0, steps}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy",  {31'd0, busy},  32'd0);
    check("rst_mid_steps", {24'd0, steps}, 32'd0);
    check("rst_mid_flags", {30'd0, done, error}, 32'd0);
    check("rst_mid_ctrl",  {16'd0, clr_sel, ld_sel, mux_a, mux_b, alu, sh_clr_n, sh_ld_n, sh_mode},
                           {16'd0, 3'd7, 3'd7, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 2'b11});
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_stays", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
